// File: rtl/instruction_fetch_pkg.sv
// Shared RISC-V package: fetch-stage state type, NOP encoding and instruction field positions.
package pa_riscv;

    typedef enum logic [1:0] {
        FETCH_IDLE,
        FETCH_REQ,
        FETCH_HOLD,
        FETCH_HALT
    } fetchState_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam int unsigned OPCODE_LSB  = 0;
    localparam int unsigned OPCODE_MSB  = 6;
    localparam int unsigned FUNCT3_LSB  = 12;
    localparam int unsigned FUNCT3_MSB  = 14;
    localparam int unsigned FUNCT7_BIT5 = 30;

    function automatic logic isMisaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/instruction_fetch_program_counter.sv
// Program counter register with +4 adder, branch mux and sticky misaligned-target flag.
module program_counter
    import pa_riscv::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_srst,
    input  logic        i_load,
    input  logic        i_branchSel,
    input  logic [31:0] i_target,
    output logic [31:0] o_pc,
    output logic [31:0] o_pcPlus4,
    output logic        o_misaligned
);

    assign o_pcPlus4 = o_pc + 32'd4;

    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            o_pc         <= RESET_PC;
            o_misaligned <= 1'b0;
        end else if (i_load) begin
            if (!i_branchSel) begin
                o_pc <= o_pcPlus4;
            end else if (isMisaligned(i_target)) begin
                // a bad target leaves the PC on the offending branch
                o_misaligned <= 1'b1;
            end else begin
                o_pc <= i_target;
            end
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: request/ack instruction fetch, instruction register and PC advance on retire.
module instruction_fetch
    import pa_riscv::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_srst,
    output logic        o_imemReq,
    output logic [31:0] o_imemAddr,
    input  logic        i_imemAck,
    input  logic [31:0] i_imemData,
    output logic        o_instrValid,
    output logic [31:0] o_instr,
    output logic [6:0]  o_operand,
    output logic [2:0]  o_funct3,
    output logic        o_funct7bit5,
    output logic [31:0] o_pc,
    output logic [31:0] o_pcPlus4,
    input  logic        i_retire,
    input  logic        i_branchCondition,
    input  logic [31:0] i_branchTarget,
    output logic        o_misaligned
);

    fetchState_t state;
    logic        pcLoad;

    assign pcLoad = (state == FETCH_HOLD) && i_retire;

    program_counter #(
        .RESET_PC(RESET_PC)
    ) u_programCounter (
        .i_clk        (i_clk),
        .i_srst       (i_srst),
        .i_load       (pcLoad),
        .i_branchSel  (i_branchCondition),
        .i_target     (i_branchTarget),
        .o_pc         (o_pc),
        .o_pcPlus4    (o_pcPlus4),
        .o_misaligned (o_misaligned)
    );

    assign o_imemAddr   = o_pc;
    assign o_operand    = o_instr[OPCODE_MSB:OPCODE_LSB];
    assign o_funct3     = o_instr[FUNCT3_MSB:FUNCT3_LSB];
    assign o_funct7bit5 = o_instr[FUNCT7_BIT5];

    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            state        <= FETCH_IDLE;
            o_imemReq    <= 1'b0;
            o_instrValid <= 1'b0;
            o_instr      <= NOP_INSTR;
        end else begin
            case (state)
                FETCH_IDLE: begin
                    state     <= FETCH_REQ;
                    o_imemReq <= 1'b1;
                end
                FETCH_REQ: begin
                    if (i_imemAck) begin
                        state        <= FETCH_HOLD;
                        o_imemReq    <= 1'b0;
                        o_instrValid <= 1'b1;
                        o_instr      <= i_imemData;
                    end
                end
                FETCH_HOLD: begin
                    if (i_retire) begin
                        o_instrValid <= 1'b0;
                        // same alignment test as the PC so HALT never issues a stray request
                        if (i_branchCondition && isMisaligned(i_branchTarget)) begin
                            state <= FETCH_HALT;
                        end else begin
                            state     <= FETCH_REQ;
                            o_imemReq <= 1'b1;
                        end
                    end
                end
                FETCH_HALT: begin
                    state <= FETCH_HALT;
                end
                default: begin
                    state <= FETCH_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios plus randomized cycles vs a reference model.
module tb_instruction_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        srst = 1'b1;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemAck = 1'b0;
    logic [31:0] imemData = '0;
    logic        instrValid;
    logic [31:0] instr;
    logic [6:0]  operand;
    logic [2:0]  funct3;
    logic        funct7bit5;
    logic [31:0] pc;
    logic [31:0] pcPlus4;
    logic        retire = 1'b0;
    logic        branchCondition = 1'b0;
    logic [31:0] branchTarget = '0;
    logic        misaligned;

    int tests = 0;
    int fails = 0;

    // reference model: what the fetch stage is doing, in plain terms
    logic [31:0] mPc = RST_PC;
    logic [31:0] mInstr = NOP;
    bit          mStarting = 1'b1;
    bit          mFetching = 1'b0;
    bit          mHolding = 1'b0;
    bit          mMis = 1'b0;

    instruction_fetch #(
        .RESET_PC(RST_PC)
    ) dut (
        .i_clk             (clk),
        .i_srst            (srst),
        .o_imemReq         (imemReq),
        .o_imemAddr        (imemAddr),
        .i_imemAck         (imemAck),
        .i_imemData        (imemData),
        .o_instrValid      (instrValid),
        .o_instr           (instr),
        .o_operand         (operand),
        .o_funct3          (funct3),
        .o_funct7bit5      (funct7bit5),
        .o_pc              (pc),
        .o_pcPlus4         (pcPlus4),
        .i_retire          (retire),
        .i_branchCondition (branchCondition),
        .i_branchTarget    (branchTarget),
        .o_misaligned      (misaligned)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        if (srst) begin
            mPc = RST_PC; mInstr = NOP; mStarting = 1'b1;
            mFetching = 1'b0; mHolding = 1'b0; mMis = 1'b0;
        end else if (mStarting) begin
            mStarting = 1'b0; mFetching = 1'b1;
        end else if (mFetching) begin
            if (imemAck) begin
                mInstr = imemData; mFetching = 1'b0; mHolding = 1'b1;
            end
        end else if (mHolding && retire) begin
            mHolding = 1'b0;
            if (branchCondition && (branchTarget % 4 != 0)) begin
                mMis = 1'b1;
            end else begin
                mPc = branchCondition ? branchTarget : mPc + 32'd4;
                mFetching = 1'b1;
            end
        end
        #1;
    endtask

    task automatic doReset();
        srst = 1'b1; imemAck = 1'b0; retire = 1'b0; branchCondition = 1'b0;
        tick();
        srst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        srst = 1'b1; imemAck = 1'b1;
        tick(); tick();
        tests++;
        if (imemReq !== 1'b0 || instrValid !== 1'b0 || misaligned !== 1'b0) begin
            fails++; $display("FAIL reset_flags req=%b valid=%b mis=%b required 0/0/0", imemReq, instrValid, misaligned);
        end
        tests++;
        if (pc !== RST_PC || instr !== NOP || operand !== 7'b0010011) begin
            fails++; $display("FAIL reset_regs pc=%h instr=%h op=%b required %h/%h/0010011", pc, instr, operand, RST_PC, NOP);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] expAddr;
        expAddr = RST_PC;
        srst = 1'b1; tick();
        srst = 1'b0; imemAck = 1'b1; retire = 1'b1; branchCondition = 1'b0; imemData = NOP;
        for (int i = 0; i < 6; i++) begin
            tick();
            tests++;
            if (imemReq !== (i % 2 == 0)) begin
                fails++; $display("FAIL seq_req[%0d] got=%b required %b", i, imemReq, (i % 2 == 0));
            end
            if (i % 2 == 0) begin
                tests++;
                if (imemAddr !== expAddr) begin
                    fails++; $display("FAIL seq_addr[%0d] got=%h required %h", i, imemAddr, expAddr);
                end
                expAddr = expAddr + 32'd4;
            end
        end
        retire = 1'b0;
    endtask

    task automatic test_wait_states();
        doReset();
        imemData = 32'h0062_82B3;
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (imemReq !== 1'b1 || imemAddr !== RST_PC) begin
                fails++; $display("FAIL wait_req[%0d] req=%b addr=%h required 1/%h", i, imemReq, imemAddr, RST_PC);
            end
            imemAck = (i == 3);
            tick();
        end
        imemAck = 1'b0;
        tests++;
        if (instrValid !== 1'b1 || instr !== 32'h0062_82B3) begin
            fails++; $display("FAIL wait_instr valid=%b instr=%h required 1/006282b3", instrValid, instr);
        end
        tests++;
        if (operand !== 7'b0110011 || funct3 !== 3'd0 || funct7bit5 !== 1'b0) begin
            fails++; $display("FAIL wait_fields op=%b f3=%0d f7b5=%b required 0110011/0/0", operand, funct3, funct7bit5);
        end
    endtask

    task automatic test_branch();
        doReset();
        imemAck = 1'b1; imemData = $urandom; tick();
        retire = 1'b1; branchCondition = 1'b1; branchTarget = 32'h10; imemAck = 1'b0; tick();
        tests++;
        if (imemAddr !== 32'h10 || imemReq !== 1'b1) begin
            fails++; $display("FAIL branch_to10 addr=%h req=%b required 00000010/1", imemAddr, imemReq);
        end
        branchTarget = 32'h80; tick();
        tests++;
        if (imemAddr !== 32'h10 || imemReq !== 1'b1 || instrValid !== 1'b0) begin
            fails++; $display("FAIL spurious_retire addr=%h req=%b valid=%b required 00000010/1/0", imemAddr, imemReq, instrValid);
        end
        retire = 1'b0; imemAck = 1'b1; tick();
        imemAck = 1'b0; retire = 1'b1; branchTarget = 32'h40; tick();
        retire = 1'b0; branchCondition = 1'b0;
        tests++;
        if (imemAddr !== 32'h40 || imemReq !== 1'b1 || instrValid !== 1'b0) begin
            fails++; $display("FAIL branch_to40 addr=%h req=%b valid=%b required 00000040/1/0", imemAddr, imemReq, instrValid);
        end
    endtask

    task automatic test_misaligned();
        doReset();
        imemAck = 1'b1; tick();
        retire = 1'b1; branchCondition = 1'b1; branchTarget = 32'h42; tick();
        tests++;
        if (misaligned !== 1'b1 || imemReq !== 1'b0 || instrValid !== 1'b0 || pc !== RST_PC) begin
            fails++; $display("FAIL mis_enter mis=%b req=%b valid=%b pc=%h required 1/0/0/%h", misaligned, imemReq, instrValid, pc, RST_PC);
        end
        branchTarget = 32'h40;
        for (int i = 0; i < 5; i++) begin
            tick();
            tests++;
            if (imemReq !== 1'b0 || misaligned !== 1'b1 || instrValid !== 1'b0) begin
                fails++; $display("FAIL halt_hold[%0d] req=%b mis=%b valid=%b required 0/1/0", i, imemReq, misaligned, instrValid);
            end
        end
        retire = 1'b0; branchCondition = 1'b0; srst = 1'b1; tick();
        tests++;
        if (misaligned !== 1'b0 || pc !== RST_PC) begin
            fails++; $display("FAIL halt_reset mis=%b pc=%h required 0/%h", misaligned, pc, RST_PC);
        end
        srst = 1'b0;
    endtask

    task automatic test_wrap();
        doReset();
        imemAck = 1'b1; tick();
        retire = 1'b1; branchCondition = 1'b1; branchTarget = 32'hFFFF_FFFC; tick();
        retire = 1'b0; branchCondition = 1'b0; tick();
        tests++;
        if (pc !== 32'hFFFF_FFFC || pcPlus4 !== 32'h0 || instrValid !== 1'b1) begin
            fails++; $display("FAIL wrap_plus4 pc=%h plus4=%h valid=%b required fffffffc/00000000/1", pc, pcPlus4, instrValid);
        end
        retire = 1'b1; tick();
        retire = 1'b0;
        tests++;
        if (imemAddr !== 32'h0 || imemReq !== 1'b1) begin
            fails++; $display("FAIL wrap_addr addr=%h req=%b required 00000000/1", imemAddr, imemReq);
        end
    endtask

    task automatic test_reset_mid_req();
        doReset();
        imemAck = 1'b0; imemData = 32'hDEAD_BEEF; tick();
        srst = 1'b1; tick();
        srst = 1'b0; imemAck = 1'b1; tick();
        imemAck = 1'b0;
        tests++;
        if (instr !== NOP || instrValid !== 1'b0) begin
            fails++; $display("FAIL midreq_instr instr=%h valid=%b required %h/0", instr, instrValid, NOP);
        end
        tests++;
        if (imemReq !== 1'b1 || imemAddr !== RST_PC) begin
            fails++; $display("FAIL midreq_restart req=%b addr=%h required 1/%h", imemReq, imemAddr, RST_PC);
        end
    endtask

    task automatic test_random();
        doReset();
        for (int i = 0; i < 400; i++) begin
            srst            = ($urandom_range(63) == 0);
            imemAck         = $urandom_range(1);
            imemData        = $urandom;
            retire          = ($urandom_range(4) < 2);
            branchCondition = ($urandom_range(3) == 0);
            branchTarget    = $urandom;
            if ($urandom_range(15) != 0) branchTarget[1:0] = 2'b00;
            tick();
            tests++;
            if (imemReq !== mFetching || instrValid !== mHolding || misaligned !== mMis) begin
                fails++; $display("FAIL rand_ctrl[%0d] req=%b valid=%b mis=%b required %b/%b/%b", i, imemReq, instrValid, misaligned, mFetching, mHolding, mMis);
            end
            tests++;
            if (pc !== mPc || imemAddr !== mPc || pcPlus4 !== mPc + 32'd4) begin
                fails++; $display("FAIL rand_pc[%0d] pc=%h addr=%h plus4=%h required pc %h", i, pc, imemAddr, pcPlus4, mPc);
            end
            tests++;
            if (instr !== mInstr || operand !== mInstr[6:0] || funct3 !== mInstr[14:12] || funct7bit5 !== mInstr[30]) begin
                fails++; $display("FAIL rand_instr[%0d] instr=%h op=%b f3=%b f7b5=%b required instr %h", i, instr, operand, funct3, funct7bit5, mInstr);
            end
        end
        srst = 1'b0; retire = 1'b0; imemAck = 1'b0;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_wait_states();
        test_branch();
        test_misaligned();
        test_wrap();
        test_reset_mid_req();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
